// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces presses and
// releases, and reports the pressed key as a 4-bit hex code.
// Optional feature macro: KEYPAD_SYNC_EN (2-flop row synchronizer).
module keypad_scanner #(
  parameter int SCAN_DIV        = 40000,
  parameter int DEBOUNCE_CYCLES = 800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // True when exactly one row line is pulled low.
  function automatic logic is_single_low(input logic [3:0] p);
    case (p)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Index of the single low row line.
  function automatic logic [1:0] row_index(input logic [3:0] p);
    case (p)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Keypad legend: (row,col) -> hex code; '*' maps to E and '#' to F.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      4'hF: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  logic [3:0] rows_s;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_r, sync2_r;

  // Two-flop synchronizer for the asynchronous row lines (idle = all high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= rows;
      sync2_r <= sync1_r;
    end
  end

  assign rows_s = sync2_r;
`else
  assign rows_s = rows;
`endif

  state_t        state_r, state_next_s;
  logic [1:0]    col_idx_r, col_idx_next_s;
  logic [DW-1:0] dwell_r, dwell_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic [3:0]    cap_row_r, cap_row_next_s;
  logic [3:0]    cols_r, cols_next_s;
  logic [3:0]    key_r, key_next_s;
  logic          key_valid_r, key_valid_next_s;
  logic          key_held_r, key_held_next_s;

  // State and output registers; everything returns to idle on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      dwell_r     <= '0;
      cnt_r       <= '0;
      cap_row_r   <= 4'hF;
      cols_r      <= 4'b1110;
      key_r       <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      col_idx_r   <= col_idx_next_s;
      dwell_r     <= dwell_next_s;
      cnt_r       <= cnt_next_s;
      cap_row_r   <= cap_row_next_s;
      cols_r      <= cols_next_s;
      key_r       <= key_next_s;
      key_valid_r <= key_valid_next_s;
      key_held_r  <= key_held_next_s;
    end
  end

  // Next-state logic: scan columns, confirm a press, hold, confirm the release.
  always_comb begin
    state_next_s     = state_r;
    col_idx_next_s   = col_idx_r;
    dwell_next_s     = dwell_r;
    cnt_next_s       = cnt_r;
    cap_row_next_s   = cap_row_r;
    key_next_s       = key_r;
    key_valid_next_s = 1'b0;
    key_held_next_s  = key_held_r;

    case (state_r)
      SCAN: begin
        // Rows are only looked at on the last dwell cycle so drive and sync settle.
        if (dwell_r == DWELL_LAST) begin
          dwell_next_s = '0;
          if (is_single_low(rows_s)) begin
            cap_row_next_s = rows_s;
            cnt_next_s     = '0;
            state_next_s   = DEBOUNCE;
          end else begin
            col_idx_next_s = col_idx_r + 2'd1;
          end
        end else begin
          dwell_next_s = dwell_r + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s == cap_row_r) begin
          if (cnt_r == CNT_LAST) begin
            key_next_s       = key_code(row_index(cap_row_r), col_idx_r);
            key_valid_next_s = 1'b1;
            key_held_next_s  = 1'b1;
            state_next_s     = HELD;
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          state_next_s = SCAN;
          dwell_next_s = '0;
        end
      end
      HELD: begin
        if (rows_s == 4'hF) begin
          state_next_s = RELEASE;
          cnt_next_s   = '0;
        end else begin
          state_next_s = HELD;
        end
      end
      RELEASE: begin
        if (rows_s == 4'hF) begin
          if (cnt_r == CNT_LAST) begin
            key_held_next_s = 1'b0;
            state_next_s    = SCAN;
            col_idx_next_s  = col_idx_r + 2'd1;
            dwell_next_s    = '0;
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end else begin
          // A row dropped again before release settled: contact bounce.
          state_next_s = HELD;
        end
      end
      default: begin
        state_next_s = SCAN;
        dwell_next_s = '0;
      end
    endcase

    cols_next_s = ~(4'b0001 << col_idx_next_s);
  end

  assign cols      = cols_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: physical keypad model driving rows from cols, with a
// run-length reference model of scan/debounce/hold/release. Works with or
// without KEYPAD_SYNC_EN.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;
`ifdef KEYPAD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  bit         pressed [4][4];
  logic [3:0] code_tbl [16];

  // reference model state (run-length view of the keypad behaviour)
  int         m_col, m_t, m_run, m_rel;
  bit         m_held, m_cand, m_valid;
  logic [3:0] m_cap, m_key;
  logic [3:0] hist [2];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } kv_t;
  kv_t tbl [16];

  function automatic int low_count(input logic [3:0] p);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!p[i]) n++;
    return n;
  endfunction

  function automatic int row_of(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] phys_rows();
    logic [3:0] r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (pressed[ri][ci] && cols[ci] == 1'b0) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic release_all();
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++) pressed[ri][ci] = 1'b0;
  endtask

  task automatic model_reset();
    m_col = 0; m_t = 0; m_run = 0; m_rel = 0;
    m_held = 1'b0; m_cand = 1'b0; m_valid = 1'b0;
    m_cap = 4'hF; m_key = 4'h0;
    hist[0] = 4'hF; hist[1] = 4'hF;
  endtask

  task automatic model_step(input logic [3:0] r_in);
    logic [3:0] s;
    s = (LAT == 0) ? r_in : hist[1];
    hist[1] = hist[0];
    hist[0] = r_in;
    m_valid = 1'b0;
    if (m_held) begin
      if (s == 4'hF) begin
        m_rel++;
        if (m_rel == D + 1) begin
          m_held = 1'b0; m_rel = 0; m_col = (m_col + 1) % 4; m_t = 0;
        end
      end else begin
        m_rel = 0;
      end
    end else if (m_cand) begin
      if (s == m_cap) begin
        m_run++;
        if (m_run == D + 1) begin
          m_key = code_tbl[row_of(m_cap) * 4 + m_col];
          m_valid = 1'b1; m_held = 1'b1; m_cand = 1'b0; m_rel = 0;
        end
      end else begin
        m_cand = 1'b0; m_t = 0;
      end
    end else begin
      if (m_t == S - 1) begin
        m_t = 0;
        if (low_count(s) == 1) begin
          m_cand = 1'b1; m_cap = s; m_run = 1;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [9:0] exp_v, act_v;
    exp_v = {4'(15 - (1 << m_col)), m_key, m_valid, m_held};
    act_v = {cols, key, key_valid, key_held};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got cols=%b key=%h valid=%b held=%b, expected cols=%b key=%h valid=%b held=%b",
               $time, act_v[9:6], act_v[5:2], act_v[1], act_v[0],
               exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // one clock: drive rows for the next edge, advance the model, check after the edge
  task automatic cycle();
    rows = phys_rows();
    model_step(rows);
    @(negedge clk);
    if (key_valid) n_pulses++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_valid(input string name, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      cycle();
      if (key_valid) seen = 1'b1;
    end
    check_val(name, int'(seen), 1);
  endtask

  task automatic wait_release(input string name, input int bound);
    bit gone = !key_held;
    for (int i = 0; i < bound && !gone; i++) begin
      cycle();
      if (!key_held) gone = 1'b1;
    end
    check_val(name, int'(gone), 1);
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({cols, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s got cols=%b key=%h valid=%b held=%b expected cols=1110 key=0 valid=0 held=0",
               name, cols, key, key_valid, key_held);
    end
  endtask

  initial begin
    int p0, r, c;
    code_tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    tbl[0]  = '{0, 0, 4'h1}; tbl[1]  = '{0, 1, 4'h2}; tbl[2]  = '{0, 2, 4'h3}; tbl[3]  = '{0, 3, 4'hA};
    tbl[4]  = '{1, 0, 4'h4}; tbl[5]  = '{1, 1, 4'h5}; tbl[6]  = '{1, 2, 4'h6}; tbl[7]  = '{1, 3, 4'hB};
    tbl[8]  = '{2, 0, 4'h7}; tbl[9]  = '{2, 1, 4'h8}; tbl[10] = '{2, 2, 4'h9}; tbl[11] = '{2, 3, 4'hC};
    tbl[12] = '{3, 0, 4'hE}; tbl[13] = '{3, 1, 4'h0}; tbl[14] = '{3, 2, 4'hF}; tbl[15] = '{3, 3, 4'hD};

    release_all();
    rows  = 4'hF;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;

    // idle scanning
    p0 = n_pulses;
    run(64);
    check_val("idle_no_valid", n_pulses - p0, 0);

    // press and hold row1/col2
    p0 = n_pulses;
    pressed[1][2] = 1'b1;
    run(40);
    release_all();
    run(30);
    check_val("hold_one_pulse", n_pulses - p0, 1);
    check_val("hold_key", int'(key), 6);
    check_val("hold_released", int'(key_held), 0);

    // press '0' with bounce once column 1 is driven
    p0 = n_pulses;
    for (int i = 0; i < 20 && cols != 4'b1101; i++) cycle();
    check_val("bounce_col_reached", int'(cols == 4'b1101), 1);
    for (int k = 0; k < 3; k++) begin
      pressed[3][1] = (k % 2 == 0);
      cycle();
    end
    check_val("bounce_no_pulse", n_pulses - p0, 0);
    pressed[3][1] = 1'b1;
    run(40);
    check_val("bounce_one_pulse", n_pulses - p0, 1);
    check_val("bounce_key", int'(key), 0);
    release_all();
    wait_release("bounce_release", 40);
    run(4);

    // release bounce on '5'
    p0 = n_pulses;
    pressed[1][1] = 1'b1;
    wait_valid("relb_accept", 60);
    run(3);
    release_all();
    run(3);
    pressed[1][1] = 1'b1;
    run(2);
    release_all();
    run(5);
    check_val("relb_still_held", int'(key_held), 1);
    wait_release("relb_release", 20);
    check_val("relb_one_pulse", n_pulses - p0, 1);
    run(4);

    // two keys in column 0
    p0 = n_pulses;
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    run(40);
    check_val("multi_no_pulse", n_pulses - p0, 0);
    check_val("multi_key_unchanged", int'(key), 5);
    release_all();
    run(10);

    // reset while holding 'D'
    pressed[3][3] = 1'b1;
    wait_valid("rst_first_accept", 60);
    check_val("rst_first_key", int'(key), 13);
    run(5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    p0 = n_pulses;
    wait_valid("rst_reaccept", 60);
    check_val("rst_key", int'(key), 13);
    check_val("rst_one_pulse", n_pulses - p0, 1);
    release_all();
    wait_release("rst_release", 40);
    run(4);

    // key map table
    for (int i = 0; i < 16; i++) begin
      pressed[tbl[i].r][tbl[i].c] = 1'b1;
      wait_valid("map_accept", 80);
      check_val("map_key", int'(key), int'(tbl[i].code));
      release_all();
      wait_release("map_release", 40);
      run(3);
    end

    // randomized presses with bounce, against the reference model
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pressed[r][c] = 1'b1;
      if ($urandom_range(0, 9) == 0) pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      for (int b = $urandom_range(0, 3); b > 0; b--) begin
        run($urandom_range(1, 3));
        release_all();
        run($urandom_range(1, 2));
        pressed[r][c] = 1'b1;
      end
      run($urandom_range(1, 40));
      release_all();
      run($urandom_range(1, 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
